ecc_frame_loader: RTL and testbench
===================================

Name: ecc_frame_loader

Overview:
- Sits directly downstream of the ECC input buffer/LLR translation stage and directly upstream of the NB-LDPC decoder core.
- Counts CE-qualified ADC beats to detect when a full codeword (PERIOD columns) has been written into the buffer.
- Snapshots the buffer's LLR and info-symbol vectors into a holding register and hands the frame to the decoder with a valid/ready handshake.
- Holds the frame stable until the decoder reports completion, and counts frames dropped because the decoder was still occupied.

Parameters:
- PERIOD, 32, number of CE beats per codeword frame.
- COUNTER_BIT, 5, width of the beat counter; PERIOD <= 2^COUNTER_BIT.
- SYMBOL_NUM, 288, total code symbols.
- INFO_NUM, 256, information symbols.
- FIELD, 3, LLR entries per symbol.
- LLR_BIT, 3, bits per LLR entry.
- ADC_BIT, 3, bits per raw ADC symbol.
- ID_BIT, 8, width of the frame sequence number and of the drop counter.

Ports:
- ADC_CLK  in  1  sole clock; all state on rising edge.
- SYS_RST  in  1  asynchronous, active-high reset.
- START  in  1  single-cycle pulse; begins a new frame fill.
- CE  in  1  buffer write enable; one column beat per high cycle.
- CIM_E  in  1  mode (1 = CIM/ADC data, 0 = sense-amp data); sampled at START.
- ECC_LLR_IN  in  SYMBOL_NUM*FIELD*LLR_BIT  LLR vector from the translation stage.
- ECC_SYMBOL_IN  in  INFO_NUM*ADC_BIT  raw info symbols from the buffer.
- DEC_READY  in  1  decoder can accept a frame.
- DEC_DONE  in  1  single-cycle pulse; decoder has finished with the held frame.
- FRAME_VALID  out  1  held frame is offered to the decoder.
- FRAME_LLR  out  SYMBOL_NUM*FIELD*LLR_BIT  held LLR vector.
- FRAME_SYMBOL  out  INFO_NUM*ADC_BIT  held info symbols.
- FRAME_MODE  out  1  CIM_E latched for the held frame.
- FRAME_ID  out  ID_BIT  sequence number of the held frame.
- BUSY  out  1  decoder owns the held frame.
- FILLING  out  1  fill in progress.
- DROP_CNT  out  ID_BIT  saturating count of dropped frames.
- OVERFLOW  out  1  sticky; set on the first drop.

Behaviour:
- Reset: all outputs 0, all holding registers 0, both FSMs to idle, internal next-ID counter 0.
- Fill FSM states: F_IDLE, F_FILL, F_SNAP.
  - F_IDLE: START → F_FILL; beat counter := 0; mode register := CIM_E. CE is ignored in F_IDLE.
  - F_FILL: each CE cycle increments the counter. CE with counter == PERIOD-1 → F_SNAP.
  - F_SNAP: lasts exactly one cycle, because the buffer output is registered. At the end of this cycle the snapshot is attempted, then the FSM returns to F_IDLE.
  - START in F_FILL aborts the partial frame: counter := 0, mode re-sampled, FSM stays in F_FILL.
  - START in F_SNAP is ignored.
  - FILLING = (state != F_IDLE).
- Output FSM states: O_EMPTY, O_VALID, O_BUSY.
  - A snapshot is accepted if the output FSM is O_EMPTY, or O_BUSY with DEC_DONE in the same cycle.
  - On accept: FRAME_LLR, FRAME_SYMBOL and FRAME_MODE load; FRAME_ID := next-ID; next-ID increments, wrapping modulo 2^ID_BIT; output FSM → O_VALID.
  - Otherwise the snapshot is dropped: DROP_CNT increments (saturating at all-ones), OVERFLOW := 1 (sticky until reset), and the held frame is unchanged.
  - O_VALID: FRAME_VALID = 1. FRAME_VALID & DEC_READY at an edge → O_BUSY.
  - O_BUSY: BUSY = 1. DEC_DONE → O_EMPTY, unless a snapshot is accepted in the same cycle, in which case → O_VALID.
  - DEC_DONE outside O_BUSY is ignored.
- Held outputs stay constant from load until the next accept, through O_VALID, O_BUSY and O_EMPTY.
- Latency: if the last CE is at cycle t, FRAME_VALID is high from cycle t+2 (no drop case).
- Edge cases:
  - START and the last CE beat in the same cycle: START wins; the counter resets and no snapshot occurs.
  - Reset asserted mid-fill or mid-handshake immediately clears everything; no partial frame is retained.

Test Plan:
- Reset, then START with CIM_E=1, then 32 consecutive CE beats with a ramp pattern; DEC_READY=0. Required: FRAME_VALID rises 2 cycles after the 32nd beat, FRAME_LLR equals ECC_LLR_IN at t+1, FRAME_MODE=1, FRAME_ID=0.
- Same frame, with CE gapped (toggling every other cycle). Required: snapshot only after 32 CE-high cycles; FILLING high throughout the fill.
- FRAME_VALID=1, DEC_READY pulsed. Required: BUSY=1 and FRAME_VALID=0 the next cycle; after DEC_DONE, BUSY=0, and a second frame gets FRAME_ID=1.
- Second frame completes while BUSY, with no DEC_DONE. Required: DROP_CNT=1, OVERFLOW=1, FRAME_LLR unchanged. Repeat 300 drops: DROP_CNT saturates at 255.
- DEC_DONE coincides with the snapshot cycle. Required: new frame accepted, FRAME_VALID=1, DROP_CNT unchanged.
- START re-asserted at beat 20, then 32 beats; separately, SYS_RST asserted at beat 10. Required: snapshot only after 32 beats following the latest START; reset clears all outputs to 0 asynchronously.

Source files
------------

// File: rtl/ecc_frame_loader.sv
// ecc_frame_loader: counts CE beats into a codeword, snapshots the LLR/info
// vectors from the input buffer and hands the held frame to the NB-LDPC
// decoder through a valid/ready/done handshake, counting frames dropped
// while the decoder still owns the previous one.
module ecc_frame_loader #(
    parameter int PERIOD      = 32,
    parameter int COUNTER_BIT = 5,
    parameter int SYMBOL_NUM  = 288,
    parameter int INFO_NUM    = 256,
    parameter int FIELD       = 3,
    parameter int LLR_BIT     = 3,
    parameter int ADC_BIT     = 3,
    parameter int ID_BIT      = 8
) (
    input  logic                                 ADC_CLK,
    input  logic                                 SYS_RST,
    input  logic                                 START,
    input  logic                                 CE,
    input  logic                                 CIM_E,
    input  logic [SYMBOL_NUM*FIELD*LLR_BIT-1:0]  ECC_LLR_IN,
    input  logic [INFO_NUM*ADC_BIT-1:0]          ECC_SYMBOL_IN,
    input  logic                                 DEC_READY,
    input  logic                                 DEC_DONE,
    output logic                                 FRAME_VALID,
    output logic [SYMBOL_NUM*FIELD*LLR_BIT-1:0]  FRAME_LLR,
    output logic [INFO_NUM*ADC_BIT-1:0]          FRAME_SYMBOL,
    output logic                                 FRAME_MODE,
    output logic [ID_BIT-1:0]                    FRAME_ID,
    output logic                                 BUSY,
    output logic                                 FILLING,
    output logic [ID_BIT-1:0]                    DROP_CNT,
    output logic                                 OVERFLOW
);

    localparam logic [COUNTER_BIT-1:0] LAST_BEAT = COUNTER_BIT'(PERIOD - 1);

    typedef enum logic [1:0] {F_IDLE, F_FILL, F_SNAP} fstate_t;
    typedef enum logic [1:0] {O_EMPTY, O_VALID, O_BUSY} ostate_t;

    fstate_t                          f_state_q, f_state_d;
    logic [COUNTER_BIT-1:0]           beat_q, beat_d;
    logic                             mode_q, mode_d;
    ostate_t                          o_state_q, o_state_d;
    logic [SYMBOL_NUM*FIELD*LLR_BIT-1:0] llr_q;
    logic [INFO_NUM*ADC_BIT-1:0]      sym_q;
    logic                             fmode_q;
    logic [ID_BIT-1:0]                id_q, next_id_q, drop_q;
    logic                             ovf_q;
    logic                             snap, accept, drop;

    // Fill FSM state, beat counter and sampled mode
    always_ff @(posedge ADC_CLK or posedge SYS_RST) begin
        if (SYS_RST) begin
            f_state_q <= F_IDLE;
            beat_q    <= '0;
            mode_q    <= 1'b0;
        end else begin
            f_state_q <= f_state_d;
            beat_q    <= beat_d;
            mode_q    <= mode_d;
        end
    end

    // Fill next state: START restarts a fill and beats it the same cycle
    always_comb begin
        f_state_d = f_state_q;
        beat_d    = beat_q;
        mode_d    = mode_q;
        case (f_state_q)
            F_IDLE: begin
                if (START) begin
                    f_state_d = F_FILL;
                    beat_d    = '0;
                    mode_d    = CIM_E;
                end
            end
            F_FILL: begin
                if (START) begin
                    beat_d = '0;
                    mode_d = CIM_E;
                end else if (CE) begin
                    if (beat_q == LAST_BEAT) begin
                        f_state_d = F_SNAP;
                        beat_d    = '0;
                    end else begin
                        beat_d = beat_q + COUNTER_BIT'(1);
                    end
                end
            end
            // Buffer output is registered, so wait one cycle before sampling
            F_SNAP:  f_state_d = F_IDLE;
            default: f_state_d = F_IDLE;
        endcase
    end

    // Fill outputs
    always_comb begin
        FILLING = (f_state_q != F_IDLE);
        snap    = (f_state_q == F_SNAP);
    end

    // Output FSM state register
    always_ff @(posedge ADC_CLK or posedge SYS_RST) begin
        if (SYS_RST) o_state_q <= O_EMPTY;
        else         o_state_q <= o_state_d;
    end

    // Output next state: a finishing decoder frees the slot for a same-cycle snapshot
    always_comb begin
        accept    = snap && ((o_state_q == O_EMPTY) ||
                             (o_state_q == O_BUSY && DEC_DONE));
        drop      = snap && !accept;
        o_state_d = o_state_q;
        case (o_state_q)
            O_EMPTY: if (accept) o_state_d = O_VALID;
            O_VALID: if (DEC_READY) o_state_d = O_BUSY;
            O_BUSY:  if (DEC_DONE) o_state_d = accept ? O_VALID : O_EMPTY;
            default: o_state_d = O_EMPTY;
        endcase
    end

    // Output FSM outputs
    always_comb begin
        FRAME_VALID = (o_state_q == O_VALID);
        BUSY        = (o_state_q == O_BUSY);
    end

    // Holding register, frame numbering and drop accounting
    always_ff @(posedge ADC_CLK or posedge SYS_RST) begin
        if (SYS_RST) begin
            llr_q     <= '0;
            sym_q     <= '0;
            fmode_q   <= 1'b0;
            id_q      <= '0;
            next_id_q <= '0;
            drop_q    <= '0;
            ovf_q     <= 1'b0;
        end else begin
            if (accept) begin
                llr_q     <= ECC_LLR_IN;
                sym_q     <= ECC_SYMBOL_IN;
                fmode_q   <= mode_q;
                id_q      <= next_id_q;
                next_id_q <= next_id_q + ID_BIT'(1);
            end
            if (drop) begin
                if (drop_q != '1) drop_q <= drop_q + ID_BIT'(1);
                ovf_q <= 1'b1;
            end
        end
    end

    assign FRAME_LLR    = llr_q;
    assign FRAME_SYMBOL = sym_q;
    assign FRAME_MODE   = fmode_q;
    assign FRAME_ID     = id_q;
    assign DROP_CNT     = drop_q;
    assign OVERFLOW     = ovf_q;

endmodule

// File: tb/tb_ecc_frame_loader.sv
// Bench for ecc_frame_loader: expected frames are queued when a fill that
// should be accepted is driven, and popped when FRAME_VALID rises.
module tb_ecc_frame_loader;

    localparam int LW = 288 * 3 * 3;
    localparam int SW = 256 * 3;

    logic          ADC_CLK, SYS_RST, START, CE, CIM_E, DEC_READY, DEC_DONE;
    logic [LW-1:0] ECC_LLR_IN, FRAME_LLR;
    logic [SW-1:0] ECC_SYMBOL_IN, FRAME_SYMBOL;
    logic          FRAME_VALID, FRAME_MODE, BUSY, FILLING, OVERFLOW;
    logic [7:0]    FRAME_ID, DROP_CNT;

    ecc_frame_loader dut (
        .ADC_CLK(ADC_CLK), .SYS_RST(SYS_RST), .START(START), .CE(CE), .CIM_E(CIM_E),
        .ECC_LLR_IN(ECC_LLR_IN), .ECC_SYMBOL_IN(ECC_SYMBOL_IN),
        .DEC_READY(DEC_READY), .DEC_DONE(DEC_DONE),
        .FRAME_VALID(FRAME_VALID), .FRAME_LLR(FRAME_LLR), .FRAME_SYMBOL(FRAME_SYMBOL),
        .FRAME_MODE(FRAME_MODE), .FRAME_ID(FRAME_ID), .BUSY(BUSY), .FILLING(FILLING),
        .DROP_CNT(DROP_CNT), .OVERFLOW(OVERFLOW)
    );

    initial ADC_CLK = 1'b0;
    always #5 ADC_CLK = ~ADC_CLK;

    typedef struct {
        logic [LW-1:0] llr;
        logic [SW-1:0] sym;
        logic          mode;
        logic [7:0]    id;
    } frame_t;

    frame_t        sb[$];
    frame_t        e;
    logic [7:0]    exp_id;
    logic [LW-1:0] held_llr;
    int            total, bad;

    function automatic logic [LW-1:0] rnd_llr();
        logic [LW-1:0] r;
        for (int i = 0; i < LW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [SW-1:0] rnd_sym();
        logic [SW-1:0] r;
        for (int i = 0; i < SW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic tick();
        @(posedge ADC_CLK);
        #1;
    endtask

    task automatic beats(input int n);
        for (int k = 0; k < n; k++) begin
            CE = 1'b1;
            ECC_LLR_IN = {81{32'(k)}};
            tick();
        end
        CE = 1'b0;
    endtask

    // present snapshot data in the F_SNAP cycle and optionally queue it as expected
    task automatic snap_data(input bit mode, input bit push, input bit done_snap);
        frame_t f;
        CE = 1'b0;
        ECC_LLR_IN = rnd_llr();
        ECC_SYMBOL_IN = rnd_sym();
        DEC_DONE = done_snap;
        if (push) begin
            f.llr = ECC_LLR_IN; f.sym = ECC_SYMBOL_IN; f.mode = mode; f.id = exp_id;
            sb.push_back(f);
            exp_id = exp_id + 8'd1;
        end
    endtask

    // full fill; returns during the F_SNAP cycle, before the snapshot edge
    task automatic drive_frame(input bit mode, input bit push, input bit done_snap);
        START = 1'b1; CIM_E = mode; tick();
        START = 1'b0; CIM_E = ~mode;
        beats(32);
        snap_data(mode, push, done_snap);
    endtask

    // after the snapshot edge: release DEC_DONE and scramble the buffer outputs
    task automatic after_snap();
        tick();
        DEC_DONE = 1'b0;
        ECC_LLR_IN = rnd_llr();
        ECC_SYMBOL_IN = rnd_sym();
    endtask

    task automatic test_reset();
        SYS_RST = 1'b1; START = 0; CE = 0; CIM_E = 0; DEC_READY = 0; DEC_DONE = 0;
        ECC_LLR_IN = rnd_llr(); ECC_SYMBOL_IN = rnd_sym();
        exp_id = 8'd0;
        tick(); tick();
        SYS_RST = 1'b0;
        tick();
        total++; if ({FRAME_VALID, BUSY, FILLING, OVERFLOW, FRAME_MODE} !== 5'b0) begin bad++; $display("FAIL reset_flags got=%b want=00000", {FRAME_VALID, BUSY, FILLING, OVERFLOW, FRAME_MODE}); end
        total++; if ({FRAME_ID, DROP_CNT} !== 16'h0) begin bad++; $display("FAIL reset_cnt got id=%0d drop=%0d want 0/0", FRAME_ID, DROP_CNT); end
        total++; if (FRAME_LLR !== '0 || FRAME_SYMBOL !== '0) begin bad++; $display("FAIL reset_hold got llr_lo=%h sym_lo=%h want 0", FRAME_LLR[63:0], FRAME_SYMBOL[63:0]); end
    endtask

    task automatic test_basic();
        drive_frame(1'b1, 1'b1, 1'b0);
        total++; if (FRAME_VALID !== 1'b0 || FILLING !== 1'b1) begin bad++; $display("FAIL basic_snapcyc got valid=%b filling=%b want 0/1", FRAME_VALID, FILLING); end
        after_snap();
        total++; if (FRAME_VALID !== 1'b1) begin bad++; $display("FAIL basic_latency got valid=%b want 1", FRAME_VALID); end
        total++; if (FILLING !== 1'b0) begin bad++; $display("FAIL basic_idle got filling=%b want 0", FILLING); end
        if (sb.size() == 0) begin total++; bad++; $display("FAIL basic_sb got empty want entry"); end
        else begin
            e = sb.pop_front(); held_llr = e.llr;
            total++; if (FRAME_LLR !== e.llr) begin bad++; $display("FAIL basic_llr got lo=%h want lo=%h", FRAME_LLR[63:0], e.llr[63:0]); end
            total++; if (FRAME_SYMBOL !== e.sym) begin bad++; $display("FAIL basic_sym got lo=%h want lo=%h", FRAME_SYMBOL[63:0], e.sym[63:0]); end
            total++; if (FRAME_MODE !== e.mode || FRAME_ID !== e.id) begin bad++; $display("FAIL basic_modeid got %b/%0d want %b/%0d", FRAME_MODE, FRAME_ID, e.mode, e.id); end
        end
    endtask

    task automatic test_handshake();
        tick();
        total++; if (FRAME_VALID !== 1'b1 || BUSY !== 1'b0) begin bad++; $display("FAIL hs_hold got valid=%b busy=%b want 1/0", FRAME_VALID, BUSY); end
        DEC_READY = 1'b1; tick(); DEC_READY = 1'b0;
        total++; if (FRAME_VALID !== 1'b0 || BUSY !== 1'b1) begin bad++; $display("FAIL hs_busy got valid=%b busy=%b want 0/1", FRAME_VALID, BUSY); end
        DEC_DONE = 1'b1; tick(); DEC_DONE = 1'b0;
        total++; if (FRAME_VALID !== 1'b0 || BUSY !== 1'b0) begin bad++; $display("FAIL hs_done got valid=%b busy=%b want 0/0", FRAME_VALID, BUSY); end
        total++; if (FRAME_LLR !== held_llr) begin bad++; $display("FAIL hs_heldllr got lo=%h want lo=%h", FRAME_LLR[63:0], held_llr[63:0]); end
    endtask

    task automatic test_gapped();
        int n;
        bit fill_ok;
        n = 0; fill_ok = 1'b1;
        START = 1'b1; CIM_E = 1'b0; tick();
        START = 1'b0; CIM_E = 1'b1;
        while (n < 32) begin
            CE = ~CE;
            if (CE) n++;
            ECC_LLR_IN = {81{32'(n)}};
            tick();
            if (FILLING !== 1'b1 || FRAME_VALID !== 1'b0) fill_ok = 1'b0;
        end
        total++; if (!fill_ok) begin bad++; $display("FAIL gap_fill got filling/valid wrong during fill want filling=1 valid=0"); end
        snap_data(1'b0, 1'b1, 1'b0);
        after_snap();
        total++; if (FRAME_VALID !== 1'b1) begin bad++; $display("FAIL gap_valid got %b want 1", FRAME_VALID); end
        if (sb.size() == 0) begin total++; bad++; $display("FAIL gap_sb got empty want entry"); end
        else begin
            e = sb.pop_front(); held_llr = e.llr;
            total++; if (FRAME_LLR !== e.llr) begin bad++; $display("FAIL gap_llr got lo=%h want lo=%h", FRAME_LLR[63:0], e.llr[63:0]); end
            total++; if (FRAME_MODE !== e.mode || FRAME_ID !== e.id) begin bad++; $display("FAIL gap_modeid got %b/%0d want %b/%0d", FRAME_MODE, FRAME_ID, e.mode, e.id); end
        end
        DEC_READY = 1'b1; tick(); DEC_READY = 1'b0;
    endtask

    task automatic test_drop();
        drive_frame(1'b1, 1'b0, 1'b0);
        after_snap();
        total++; if (DROP_CNT !== 8'd1 || OVERFLOW !== 1'b1) begin bad++; $display("FAIL drop_one got cnt=%0d ovf=%b want 1/1", DROP_CNT, OVERFLOW); end
        total++; if (FRAME_LLR !== held_llr || BUSY !== 1'b1) begin bad++; $display("FAIL drop_held got lo=%h busy=%b want lo=%h busy=1", FRAME_LLR[63:0], BUSY, held_llr[63:0]); end
    endtask

    task automatic test_done_at_snap();
        drive_frame(1'b0, 1'b1, 1'b1);
        after_snap();
        total++; if (FRAME_VALID !== 1'b1 || BUSY !== 1'b0) begin bad++; $display("FAIL dsnap_state got valid=%b busy=%b want 1/0", FRAME_VALID, BUSY); end
        total++; if (DROP_CNT !== 8'd1) begin bad++; $display("FAIL dsnap_drop got %0d want 1", DROP_CNT); end
        if (sb.size() == 0) begin total++; bad++; $display("FAIL dsnap_sb got empty want entry"); end
        else begin
            e = sb.pop_front(); held_llr = e.llr;
            total++; if (FRAME_LLR !== e.llr || FRAME_SYMBOL !== e.sym) begin bad++; $display("FAIL dsnap_data got lo=%h want lo=%h", FRAME_LLR[63:0], e.llr[63:0]); end
            total++; if (FRAME_ID !== e.id) begin bad++; $display("FAIL dsnap_id got %0d want %0d", FRAME_ID, e.id); end
        end
    endtask

    task automatic test_saturate();
        DEC_READY = 1'b1; tick(); DEC_READY = 1'b0;
        for (int i = 0; i < 300; i++) begin
            drive_frame(1'b1, 1'b0, 1'b0);
            after_snap();
            if (i == 252) begin
                total++; if (DROP_CNT !== 8'd254) begin bad++; $display("FAIL sat_pre got %0d want 254", DROP_CNT); end
            end
        end
        total++; if (DROP_CNT !== 8'd255 || OVERFLOW !== 1'b1) begin bad++; $display("FAIL sat_cnt got %0d/%b want 255/1", DROP_CNT, OVERFLOW); end
        total++; if (FRAME_LLR !== held_llr || FRAME_ID !== 8'd2) begin bad++; $display("FAIL sat_held got id=%0d want 2", FRAME_ID); end
        DEC_DONE = 1'b1; tick(); DEC_DONE = 1'b0;
        total++; if (BUSY !== 1'b0 || FRAME_VALID !== 1'b0) begin bad++; $display("FAIL sat_free got busy=%b valid=%b want 0/0", BUSY, FRAME_VALID); end
    endtask

    task automatic test_restart();
        START = 1'b1; CIM_E = 1'b0; tick(); START = 1'b0;
        beats(20);
        START = 1'b1; CE = 1'b1; CIM_E = 1'b0; tick(); START = 1'b0;
        beats(31);
        total++; if (FRAME_VALID !== 1'b0 || FILLING !== 1'b1) begin bad++; $display("FAIL rst20 got valid=%b filling=%b want 0/1", FRAME_VALID, FILLING); end
        // restart coinciding with what would have been the last beat
        START = 1'b1; CE = 1'b1; CIM_E = 1'b1; tick(); START = 1'b0; CE = 1'b0; CIM_E = 1'b0;
        tick();
        total++; if (FRAME_VALID !== 1'b0 || FILLING !== 1'b1) begin bad++; $display("FAIL rstlast got valid=%b filling=%b want 0/1", FRAME_VALID, FILLING); end
        beats(32);
        snap_data(1'b1, 1'b1, 1'b0);
        after_snap();
        total++; if (FRAME_VALID !== 1'b1) begin bad++; $display("FAIL rst_valid got %b want 1", FRAME_VALID); end
        if (sb.size() == 0) begin total++; bad++; $display("FAIL rst_sb got empty want entry"); end
        else begin
            e = sb.pop_front();
            total++; if (FRAME_LLR !== e.llr || FRAME_MODE !== e.mode || FRAME_ID !== e.id) begin bad++; $display("FAIL rst_frame got %b/%0d want %b/%0d", FRAME_MODE, FRAME_ID, e.mode, e.id); end
        end
    endtask

    task automatic test_reset_mid();
        DEC_READY = 1'b1; tick(); DEC_READY = 1'b0;
        START = 1'b1; CIM_E = 1'b1; tick(); START = 1'b0;
        beats(10);
        #2 SYS_RST = 1'b1;
        #1;
        total++; if ({FRAME_VALID, BUSY, FILLING, OVERFLOW, FRAME_MODE} !== 5'b0 || {FRAME_ID, DROP_CNT} !== 16'h0) begin bad++; $display("FAIL midrst_flags got %b id=%0d drop=%0d want 0", {FRAME_VALID, BUSY, FILLING, OVERFLOW, FRAME_MODE}, FRAME_ID, DROP_CNT); end
        total++; if (FRAME_LLR !== '0 || FRAME_SYMBOL !== '0) begin bad++; $display("FAIL midrst_hold got llr_lo=%h want 0", FRAME_LLR[63:0]); end
        tick(); SYS_RST = 1'b0;
        sb.delete(); exp_id = 8'd0;
        beats(32);
        tick();
        total++; if (FILLING !== 1'b0 || FRAME_VALID !== 1'b0) begin bad++; $display("FAIL midrst_noce got filling=%b valid=%b want 0/0", FILLING, FRAME_VALID); end
        drive_frame(1'b0, 1'b1, 1'b0);
        after_snap();
        if (sb.size() == 0) begin total++; bad++; $display("FAIL midrst_sb got empty want entry"); end
        else begin
            e = sb.pop_front();
            total++; if (FRAME_VALID !== 1'b1 || FRAME_ID !== e.id || FRAME_LLR !== e.llr) begin bad++; $display("FAIL midrst_frame got valid=%b id=%0d want 1/%0d", FRAME_VALID, FRAME_ID, e.id); end
        end
    endtask

    initial begin
        total = 0; bad = 0;
        test_reset();
        test_basic();
        test_handshake();
        test_gapped();
        test_drop();
        test_done_at_snap();
        test_saturate();
        test_restart();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
